// File: rtl/msx_slot_io_bridge_if.sv
// Downstream request/response channel between the MSX slot I/O bridge and the I/O fabric.
interface msx_slot_io_bridge_if;
  logic       bus_valid;
  logic       bus_ready;
  logic       bus_write;
  logic [1:0] bus_address;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;
  logic       bus_rdata_en;

  modport master (
    output bus_valid, bus_write, bus_address, bus_wdata,
    input  bus_ready, bus_rdata, bus_rdata_en
  );

  modport slave (
    input  bus_valid, bus_write, bus_address, bus_wdata,
    output bus_ready, bus_rdata, bus_rdata_en
  );
endinterface

// File: rtl/msx_slot_io_bridge.sv
// Bridges asynchronous Z80 slot I/O cycles on four ports to a synchronous valid/ready bus,
// buffering writes in a small FIFO and stretching reads with WAIT until data returns.
module msx_slot_io_bridge #(
  parameter logic [7:0] IO_BASE    = 8'h88,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           slot_a,
  input  logic [7:0]           slot_d_in,
  output logic [7:0]           slot_d_out,
  output logic                 slot_data_dir,
  input  logic                 slot_iorq_n,
  input  logic                 slot_rd_n,
  input  logic                 slot_wr_n,
  output logic                 slot_wait,
  input  logic                 init_busy,
  msx_slot_io_bridge_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_RD_DRAIN, ST_RD_REQ, ST_RD_WAIT, ST_RD_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    sync1_q, sync2_q;
  logic          wr_act_q, rd_act_q, settled_q, armed_q;
  logic          wr_act, rd_act, wr_act_s1, rd_act_s1, addr_hit, wr_acc, rd_acc;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          fifo_full, fifo_ne, fifo_phase, push, pop;
  logic [9:0]    push_data, head;
  logic          pend_vld_q, pend_vld_d, ovf_vld_q, ovf_vld_d;
  logic [9:0]    pend_data_q, pend_data_d, ovf_data_q, ovf_data_d;
  logic [1:0]    rd_addr_q;
  logic [7:0]    rdata_q;
  logic          rd_capture;

  // Strobe synchronisers and edge detection; sync bits are {iorq, rd, wr}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      settled_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      sync1_q   <= {slot_iorq_n, slot_rd_n, slot_wr_n};
      sync2_q   <= sync1_q;
      wr_act_q  <= wr_act;
      rd_act_q  <= rd_act;
      settled_q <= 1'b1;
      armed_q   <= armed_q | (settled_q & ~(wr_act | rd_act | wr_act_s1 | rd_act_s1));
    end
  end

  assign wr_act    = ~sync2_q[2] & ~sync2_q[0];
  assign rd_act    = ~sync2_q[2] & ~sync2_q[1];
  assign wr_act_s1 = ~sync1_q[2] & ~sync1_q[0];
  assign rd_act_s1 = ~sync1_q[2] & ~sync1_q[1];
  assign addr_hit  = (slot_a[7:2] == IO_BASE[7:2]);
  // A strobe already low across reset release must not look like a new access.
  assign wr_acc    = armed_q & addr_hit & wr_act & ~wr_act_q;
  assign rd_acc    = armed_q & addr_hit & rd_act & ~rd_act_q & (state_q == ST_IDLE);

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_ne    = (count_q != '0);
  assign fifo_phase = (state_q == ST_IDLE) || (state_q == ST_RD_DRAIN);
  assign head       = mem_q[rptr_q];
  assign pop        = fifo_ne & fifo_phase & bus.bus_ready;

  always_comb begin
    push        = 1'b0;
    push_data   = pend_data_q;
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    ovf_vld_d   = ovf_vld_q;
    ovf_data_d  = ovf_data_q;
    if (ovf_vld_q) begin
      if (!fifo_full) begin
        push      = 1'b1;
        push_data = ovf_data_q;
        ovf_vld_d = 1'b0;
      end
    end else if (pend_vld_q) begin
      pend_vld_d = 1'b0;
      if (!fifo_full || pop) begin
        push = 1'b1;
      end else begin
        ovf_vld_d  = 1'b1;
        ovf_data_d = pend_data_q;
      end
    end
    if (wr_acc) begin
      pend_vld_d  = 1'b1;
      pend_data_d = {slot_a[1:0], slot_d_in};
    end
  end

  assign rd_capture = bus.bus_rdata_en &
                      (((state_q == ST_RD_REQ) && bus.bus_ready) || (state_q == ST_RD_WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      pend_vld_q <= 1'b0;
      ovf_vld_q  <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_q + AW'(push);
      rptr_q     <= rptr_q + AW'(pop);
      count_q    <= count_q + CW'(push) - CW'(pop);
      pend_vld_q <= pend_vld_d;
      ovf_vld_q  <= ovf_vld_d;
      if (rd_capture) rdata_q <= bus.bus_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
    pend_data_q <= pend_data_d;
    ovf_data_q  <= ovf_data_d;
    if (rd_acc) rd_addr_q <= slot_a[1:0];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (rd_acc) state_d = ST_RD_DRAIN;
      // Queued writes must reach the bus before the read that follows them.
      ST_RD_DRAIN: if (!fifo_ne && !ovf_vld_q && !pend_vld_q) state_d = ST_RD_REQ;
      ST_RD_REQ:   if (bus.bus_ready) state_d = bus.bus_rdata_en ? ST_RD_HOLD : ST_RD_WAIT;
      ST_RD_WAIT:  if (bus.bus_rdata_en) state_d = ST_RD_HOLD;
      ST_RD_HOLD:  if (!rd_act) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.bus_valid   = 1'b0;
    bus.bus_write   = 1'b0;
    bus.bus_address = 2'b00;
    bus.bus_wdata   = 8'h00;
    if (fifo_ne && fifo_phase) begin
      bus.bus_valid   = 1'b1;
      bus.bus_write   = 1'b1;
      bus.bus_address = head[9:8];
      bus.bus_wdata   = head[7:0];
    end else if (state_q == ST_RD_REQ) begin
      bus.bus_valid   = 1'b1;
      bus.bus_address = rd_addr_q;
    end
    slot_wait     = init_busy | ovf_vld_q | (state_q == ST_RD_DRAIN) |
                    (state_q == ST_RD_REQ) | (state_q == ST_RD_WAIT);
    slot_data_dir = (state_q == ST_RD_HOLD) & rd_act;
    slot_d_out    = rdata_q;
  end
endmodule
